// File: rtl/uart_tx_arbiter.sv
// Two-source round-robin arbiter in front of a single 8N1 UART transmitter.
// Optional message lock: define UART_ARB_LOCK_EN to keep the line with one source until it sends a byte with last=1.
module uart_tx_arbiter #(
    parameter int FREQ_MHZ = 12,
    parameter int BAUDS    = 115200
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       valid0_i,
    input  logic [7:0] data0_i,
    input  logic       last0_i,
    output logic       ready0_o,
    input  logic       valid1_i,
    input  logic [7:0] data1_i,
    input  logic       last1_i,
    output logic       ready1_o,
    output logic       grant_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int CLKS_PER_BIT = FREQ_MHZ * 1_000_000 / BAUDS;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;

    logic elig0, elig1, win1, accept, baud_end;

`ifdef UART_ARB_LOCK_EN
    logic lock_vld_q, lock_vld_d;
    logic lock_id_q, lock_id_d;

    assign elig0 = valid0_i && (!lock_vld_q || !lock_id_q);
    assign elig1 = valid1_i && (!lock_vld_q || lock_id_q);
`else
    logic unused_last;

    assign unused_last = last0_i ^ last1_i;
    assign elig0 = valid0_i;
    assign elig1 = valid1_i;
`endif

    // On a tie the requester that did not win last time gets the line.
    assign win1     = (elig0 && elig1) ? !last_grant_q : elig1;
    assign accept   = (state_q == IDLE) && (elig0 || elig1) && !reset_i;
    assign baud_end = (baud_q == CW'(CLKS_PER_BIT - 1));

    assign ready0_o = accept && !win1;
    assign ready1_o = accept && win1;
    assign grant_o  = grant_q;
    assign busy_o   = (state_q != IDLE);
    assign tx_o     = tx_q;

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
`ifdef UART_ARB_LOCK_EN
        lock_vld_d   = lock_vld_q;
        lock_id_d    = lock_id_q;
`endif
        if (state_q != IDLE)
            baud_d = baud_end ? '0 : baud_q + CW'(1);

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (accept) begin
                    shift_d      = win1 ? data1_i : data0_i;
                    grant_d      = win1;
                    last_grant_d = win1;
                    tx_d         = 1'b0;
                    state_d      = START;
`ifdef UART_ARB_LOCK_EN
                    lock_vld_d   = !(win1 ? last1_i : last0_i);
                    lock_id_d    = win1;
`endif
                end
            end
            START: begin
                if (baud_end) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (baud_end)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            baud_q       <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            tx_q         <= 1'b1;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
`ifdef UART_ARB_LOCK_EN
            lock_vld_q   <= 1'b0;
            lock_id_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
`ifdef UART_ARB_LOCK_EN
            lock_vld_q   <= lock_vld_d;
            lock_id_q    <= lock_id_d;
`endif
        end
    end

endmodule
